ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Receive-only PS/2 device-to-host front end. Samples raw ps2_clk/ps2_data pins, deframes 11-bit PS/2 frames and checks them, then queues good scan-code bytes in a small FIFO. Sits directly upstream of the keyboard handler, which consumes bytes through the ready / nextdata_n handshake.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
TIMEOUT_CYC, 5000, clk cycles with no ps2_clk falling edge before a partial frame is abandoned (100 us at 50 MHz).

Ports:
clk  input  1  system clock; all logic on posedge.
clrn  input  1  reset, synchronous, active-low.
ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
data  output  8  FIFO head byte; valid while ready=1.
ready  output  1  FIFO non-empty.
nextdata_n  input  1  active-low pop request; sampled on posedge clk.
overflow  output  1  sticky: a good frame arrived while the FIFO was full.
frame_err  output  1  one-cycle pulse: frame rejected (start, stop, parity) or timed out.

Behaviour:
- Reset when clrn=0 at a posedge: FIFO empties (pointers 0), bit counter 0, timeout counter 0, sync registers all 1, data=0, ready=0, overflow=0, frame_err=0. A partial frame in flight is discarded. Reset takes priority over all other events.
- Sync: ps2_clk and ps2_data each pass through 3 flops. Falling edge detected (fe=1) when clk_sync[2:1]==2'b10. Bit value = data_sync[2] in the same cycle.
- Deframer: 11-bit shift register, LSB-first, with bit counter 0..10. Each fe shifts in one bit and increments the counter. On fe with counter=10 the frame is complete, and the checks are start==0, stop==1, and odd parity (XOR of 8 data bits and parity bit ==1). The counter returns to 0.
- Good frame: push the byte. If the FIFO is full and no pop happens in the same cycle, drop the byte and set overflow (it stays set until reset).
- Bad frame: no push. frame_err=1 for exactly the following cycle.
- Timeout: the timeout counter clears on every fe and increments while counter!=0. When it reaches TIMEOUT_CYC, the bit counter goes to 0, no push, and frame_err pulses. The counter is held at 0 while counter=0, so an idle bus never times out.
- FIFO pointers are log2(DEPTH)+1 bits wide. Empty when the pointers are equal. Full when the addresses match and the wrap bits differ. Wrap-around is natural modulo.
- Pop: at a posedge with nextdata_n=0 and ready=1, advance the read pointer. Pop while empty is ignored. Each posedge with nextdata_n=0 pops one byte. The consumer holds nextdata_n low for one cycle per byte.
- Push and pop in the same cycle are both performed and occupancy is unchanged. When full, the push is accepted because the pop frees a slot, and overflow is not set. When empty with a push, the pop is ignored and occupancy becomes 1.
- Latency: a push registered at the posedge ending the fe cycle gives ready=1 and data=byte one cycle later. Pin-to-ready is at most 4 clk cycles after the stop-bit falling edge reaches the pin.
- data is the registered or combinational read of mem[rd_ptr]. It must be stable while ready=1 and no pop occurs.

Test Plan:
1. Send frame 0x1C (parity 0) at ~10 kHz PS/2 clock -> within 4 cycles of the stop edge, ready=1 and data=0x1C. Drive nextdata_n low 1 cycle -> ready=0 next cycle. frame_err never pulses.
2. Send back-to-back frames E0 (par 0), F0 (par 1), 70 (par 0) without popping -> ready=1. Three single-cycle pops yield E0, F0, 70 in order. ready=0 after the third pop.
3. Send 0x1C with parity bit 1 -> no push, frame_err high exactly 1 cycle, ready stays 0. Then send 0x32 (par 0) -> data=0x32.
4. With DEPTH=8, send 9 good frames 0x01..0x09 with no pops -> overflow=1 after the 9th. Eight pops return 0x01..0x08, then ready=0. With the FIFO full, push and pop in the same cycle -> overflow not set by that push.
5. Send 5 clock pulses, then idle > TIMEOUT_CYC cycles -> frame_err pulse and nothing queued. Then send full frame 0x5A (par 1) -> data=0x5A.
6. With 2 bytes queued, overflow=1, and 6 bits of a frame in flight, pulse clrn low 1 cycle -> ready=0, data=0, overflow=0. Finish the old partial frame -> nothing queued. A following good frame 0x1C is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
//
// Receive-only PS/2 device-to-host front end. The raw ps2_clk / ps2_data pins
// are synchronised into the clk domain. Each ps2_clk falling edge shifts one
// bit into an 11-bit frame. A completed frame has its start, stop and odd
// parity bits checked. Good scan-code bytes go into a small FIFO that the
// keyboard handler drains through the ready / nextdata_n handshake.
//
// Parameters
//   DEPTH        FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC  clk cycles without a ps2_clk falling edge before a partial
//                frame is abandoned
//
// Ports
//   clk         in   system clock, all logic on posedge
//   clrn        in   synchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   data        out  FIFO head byte, valid while ready=1
//   ready       out  FIFO non-empty
//   nextdata_n  in   active-low pop request, one byte per low cycle
//   overflow    out  sticky: good frame dropped because the FIFO was full
//   frame_err   out  one-cycle pulse: frame rejected or timed out
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       ready,
  input  logic       nextdata_n,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]    clk_sync_q,  clk_sync_d;
  logic [2:0]    data_sync_q, data_sync_d;
  logic [10:0]   shift_q,     shift_d;
  logic [3:0]    bit_cnt_q,   bit_cnt_d;
  logic [TW-1:0] to_cnt_q,    to_cnt_d;
  logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
  logic [7:0]    data_q,      data_d;
  logic          ready_q,     ready_d;
  logic          overflow_q,  overflow_d;
  logic          frame_err_q, frame_err_d;

  logic [7:0]    mem_q [DEPTH];

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  logic          fe;
  logic          bit_in;
  logic [10:0]   frame_word;
  logic          frame_done;
  logic          frame_good;
  logic          timeout;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          head_bypass;

  // The oldest synchroniser stage is bit 2, so [2:1]==10 means the pin was
  // high one sample earlier and is now low.
  assign fe     = (clk_sync_q[2:1] == 2'b10);
  assign bit_in = data_sync_q[2];

  // Frame as it will look once the current bit is shifted in (LSB first):
  // [0]=start, [8:1]=byte, [9]=parity, [10]=stop.
  assign frame_word = {bit_in, shift_q[10:1]};
  assign frame_done = fe && (bit_cnt_q == 4'd10);
  assign frame_good = (frame_word[0] == 1'b0) && frame_word[10] && (^frame_word[9:1]);

  // An edge in the same cycle always wins over the watchdog.
  assign timeout = !fe && (bit_cnt_q != 4'd0) && (to_cnt_q == TO_LAST);

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // Pop while empty is ignored, so a simultaneous push into an empty FIFO
  // leaves exactly one entry.
  assign pop      = !nextdata_n && !fifo_empty;
  assign push_req = frame_done && frame_good;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push     = push_req && (!fifo_full || pop);

  // The byte being written becomes the new head only when it lands in the
  // slot the read pointer will point at; then the memory does not hold it
  // yet and the registered head must take it straight from the frame.
  assign head_bypass = push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]);

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    data_sync_d = {data_sync_q[1:0], ps2_data};

    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;

    if (fe) begin
      shift_d   = frame_word;
      bit_cnt_d = frame_done ? 4'd0 : bit_cnt_q + 4'd1;
      to_cnt_d  = '0;
    end else if (bit_cnt_q == 4'd0) begin
      // Idle bus: hold the watchdog so it can never fire between frames.
      to_cnt_d  = '0;
    end else if (timeout) begin
      bit_cnt_d = 4'd0;
      to_cnt_d  = '0;
    end else begin
      to_cnt_d  = to_cnt_q + TW'(1);
    end

    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);

    ready_d     = (wr_ptr_d != rd_ptr_d);
    data_d      = head_bypass ? frame_word[8:1] : mem_q[rd_ptr_d[AW-1:0]];

    overflow_d  = overflow_q || (push_req && fifo_full && !pop);
    frame_err_d = (frame_done && !frame_good) || timeout;
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Storage array has no reset so it can map onto RAM; the pointers alone
  // define which entries are live.
  always_ff @(posedge clk) begin
    if (clrn && push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= frame_word[8:1];
    end
  end

  assign data      = data_q;
  assign ready     = ready_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx_fifo
//
// Drives PS/2 frames into ps2_rx_fifo and checks it every cycle against a
// behavioural model: pin falling edges become bits after the synchroniser
// delay, bits are grouped into 11-bit frames, good bytes go into a queue.
// Directed steps add literal expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int TO    = 300;
  localparam int H     = 20;   // PS/2 clock half period in clk cycles

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .ready      (ready),
    .nextdata_n (nextdata_n),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  int checks = 0;
  int passed = 0;
  int err_pulses = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model, advanced on every posedge from the sampled inputs
  // -------------------------------------------------------------------------
  logic [7:0] q[$];
  bit         m_ovf = 0;
  bit         m_err = 0;
  bit         bits[$];
  int         age = 0;
  bit         prev_clk = 1;
  int         cyc = 0;
  int         ev_t[$];
  bit         ev_b[$];
  bit         live = 0;

  always @(posedge clk) begin
    cyc++;
    if (!clrn) begin
      q.delete(); bits.delete(); ev_t.delete(); ev_b.delete();
      m_ovf = 0; m_err = 0; age = 0; prev_clk = 1; live = 1;
    end else begin : model_step
      bit         do_pop;
      bit         good;
      bit         have_ev;
      bit         b;
      int         par;
      logic [7:0] fb;
      m_err = 0; good = 0; have_ev = 0; b = 0; fb = 0;
      // A pin fall seen now is acted on two clocks later (synchroniser).
      if (prev_clk && !ps2_clk) begin
        ev_t.push_back(cyc + 2);
        ev_b.push_back(ps2_data);
      end
      prev_clk = ps2_clk;
      do_pop = !nextdata_n && (q.size() > 0);
      if (ev_t.size() > 0 && ev_t[0] == cyc) begin
        have_ev = 1;
        b = ev_b.pop_front();
        void'(ev_t.pop_front());
      end
      if (have_ev) begin
        bits.push_back(b);
        age = 0;
        if (bits.size() == 11) begin
          par = 0;
          for (int i = 1; i <= 9; i++) par = par ^ int'(bits[i]);
          for (int i = 1; i <= 8; i++) fb[i-1] = bits[i];
          if (bits[0] == 0 && bits[10] == 1 && par == 1) good = 1;
          else m_err = 1;
          bits.delete();
        end
      end else if (bits.size() > 0) begin
        age++;
        if (age == TO) begin
          m_err = 1;
          bits.delete();
          age = 0;
        end
      end
      if (good && !(q.size() < DEPTH || do_pop)) m_ovf = 1;
      if (do_pop) void'(q.pop_front());
      if (good && (q.size() < DEPTH)) q.push_back(fb);
    end
  end

  // Compare process: outputs are stable around the negedge.
  always @(negedge clk) begin
    if (live) begin
      chk("ready", int'(ready), int'(q.size() > 0));
      if (q.size() > 0) chk("data", int'(data), int'(q[0]));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("frame_err", int'(frame_err), int'(m_err));
      if (frame_err) err_pulses++;
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    return {1'b1, p, b, 1'b0};
  endfunction

  // Sends bits [from, to) of a frame. With pop_last the consumer pops in the
  // exact cycle the last bit is acted on. lat reports how many negedges after
  // the last falling edge ready was first seen high (-1 if never).
  task automatic send_bits(input logic [10:0] fr, input int from, input int to,
                           input bit pop_last, output int lat);
    lat = -1;
    for (int i = from; i < to; i++) begin
      ps2_data = fr[i];
      wait_neg(H / 2);
      ps2_clk = 1'b0;
      if (i == to - 1 && pop_last) begin
        wait_neg(2);
        nextdata_n = 1'b0;
        wait_neg(1);
        nextdata_n = 1'b1;
        wait_neg(H - 3);
      end else if (i == to - 1) begin
        for (int k = 1; k <= H; k++) begin
          wait_neg(1);
          if (ready && lat < 0) lat = k;
        end
      end else begin
        wait_neg(H);
      end
      ps2_clk = 1'b1;
      wait_neg(H / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    int lat;
    send_bits(mk(b, 1'b0), 0, 11, 1'b0, lat);
    wait_neg(4);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] b);
    int n;
    n = 0;
    while (!ready && n < 50) begin
      wait_neg(1);
      n++;
    end
    chk({name, "_ready"}, int'(ready), 1);
    chk(name, int'(data), int'(b));
    nextdata_n = 1'b0;
    wait_neg(1);
    nextdata_n = 1'b1;
  endtask

  task automatic pulse_reset();
    clrn = 1'b0;
    wait_neg(1);
    clrn = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int lat;
    int e0;

    wait_neg(3);
    chk("rst_ready", int'(ready), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    clrn = 1'b1;
    wait_neg(5);

    // 1: single frame, latency and pop
    e0 = err_pulses;
    send_bits(mk(8'h1C, 1'b0), 0, 11, 1'b0, lat);
    chk("t1_latency_le4", int'(lat >= 1 && lat <= 4), 1);
    pop_expect("t1_data", 8'h1C);
    chk("t1_empty_after_pop", int'(ready), 0);
    chk("t1_no_err", err_pulses - e0, 0);

    // 2: back-to-back frames, ordered pops
    send(8'hE0);
    send(8'hF0);
    send(8'h70);
    pop_expect("t2_e0", 8'hE0);
    pop_expect("t2_f0", 8'hF0);
    pop_expect("t2_70", 8'h70);
    chk("t2_empty", int'(ready), 0);

    // 3: parity error, then a good frame
    e0 = err_pulses;
    send_bits(mk(8'h1C, 1'b1), 0, 11, 1'b0, lat);
    wait_neg(4);
    chk("t3_err_one_cycle", err_pulses - e0, 1);
    chk("t3_no_push", int'(ready), 0);
    send(8'h32);
    pop_expect("t3_32", 8'h32);

    // 4: overflow, drain, then push+pop while full
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("t4_overflow", int'(overflow), 1);
    for (int i = 1; i <= 8; i++) pop_expect("t4_drain", 8'(i));
    chk("t4_empty", int'(ready), 0);
    pulse_reset();
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    send_bits(mk(8'h18, 1'b0), 0, 11, 1'b1, lat);
    wait_neg(4);
    chk("t4_full_pushpop_no_ovf", int'(overflow), 0);
    for (int i = 1; i <= 8; i++) pop_expect("t4_after_pushpop", 8'(8'h10 + i));
    chk("t4_empty2", int'(ready), 0);

    // 5: partial frame times out
    e0 = err_pulses;
    send_bits(mk(8'hA5, 1'b0), 0, 5, 1'b0, lat);
    wait_neg(TO + 40);
    chk("t5_timeout_err", err_pulses - e0, 1);
    chk("t5_nothing_queued", int'(ready), 0);
    send(8'h5A);
    pop_expect("t5_5a", 8'h5A);

    // 6: reset with data queued, overflow set and a frame in flight
    for (int i = 0; i < 9; i++) send(8'(8'h21 + i));
    for (int i = 0; i < 6; i++) pop_expect("t6_pre", 8'(8'h21 + i));
    chk("t6_pre_overflow", int'(overflow), 1);
    send_bits(mk(8'h1C, 1'b0), 0, 6, 1'b0, lat);
    clrn = 1'b0;
    wait_neg(1);
    chk("t6_rst_ready", int'(ready), 0);
    chk("t6_rst_data", int'(data), 0);
    chk("t6_rst_overflow", int'(overflow), 0);
    clrn = 1'b1;
    send_bits(mk(8'h1C, 1'b0), 6, 11, 1'b0, lat);
    wait_neg(TO + 40);
    chk("t6_tail_not_queued", int'(ready), 0);
    send(8'h1C);
    pop_expect("t6_1c", 8'h1C);
    chk("t6_empty", int'(ready), 0);

    wait_neg(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
